// File: rtl/ram_port_arbiter_2m_pkg.sv
// rtl/ram_port_arbiter_2m_pkg.sv - shared types and constants for the two-master RAM port arbiter
package ram_port_arbiter_2m_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int WE_WIDTH       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // One-hot grant vector to master ID.
    function automatic logic grant_id(input logic [1:0] grant_onehot);
        return grant_onehot[1];
    endfunction

endpackage

// File: rtl/ram_port_arbiter_2m_rr_arbiter_2.sv
// rtl/ram_port_arbiter_2m_rr_arbiter_2.sv - two-way round-robin grant, purely combinational
module rr_arbiter_2
    import ram_port_arbiter_2m_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On contention, favour whoever did not win last time.
            2'b11:   grant_o = (last_grant_i == GRANT_M1) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter_2m.sv
// rtl/ram_port_arbiter_2m.sv - shares one delayed-ack RAM slave port between fetch and load/store masters
module ram_port_arbiter_2m
    import ram_port_arbiter_2m_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_stb_i,
    input  logic [WE_WIDTH-1:0]   m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_stb_i,
    input  logic [WE_WIDTH-1:0]   m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_stb_o,
    output logic [WE_WIDTH-1:0]   s_we_o,
    output logic [DATA_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic                  stray_ack_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [WE_WIDTH-1:0]   we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  stray_q, stray_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       any_req;
    logic       timeout_hit;
    logic       done;

    assign req         = {m1_stb_i, m0_stb_i};
    assign any_req     = |req;
    assign timeout_hit = (cnt_q == CNT_LAST);

    rr_arbiter_2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (s_ack_i || timeout_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= GRANT_M1;
            we_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            stray_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            stray_q      <= stray_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        stray_d      = stray_q | (s_ack_i && (state_q != ST_WAIT));
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    last_grant_d = grant_id(grant);
                    we_d         = grant[1] ? m1_we_i    : m0_we_i;
                    addr_d       = grant[1] ? m1_addr_i  : m0_addr_i;
                    wdata_d      = grant[1] ? m1_wdata_i : m0_wdata_i;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                if (s_ack_i) begin
                    rdata_d = s_rdata_i;
                    err_d   = s_err_i;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (timeout_hit) err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Responses are decoded straight from state so an async reset silences them at once.
    always_comb begin
        done        = (state_q == ST_DONE);
        s_stb_o     = (state_q == ST_ISSUE);
        s_we_o      = (state_q == ST_ISSUE) ? we_q : '0;
        s_addr_o    = addr_q;
        s_wdata_o   = wdata_q;
        m0_ack_o    = done && (last_grant_q == GRANT_M0) && !err_q;
        m0_err_o    = done && (last_grant_q == GRANT_M0) && err_q;
        m1_ack_o    = done && (last_grant_q == GRANT_M1) && !err_q;
        m1_err_o    = done && (last_grant_q == GRANT_M1) && err_q;
        m0_rdata_o  = (done && (last_grant_q == GRANT_M0)) ? rdata_q : '0;
        m1_rdata_o  = (done && (last_grant_q == GRANT_M1)) ? rdata_q : '0;
        stray_ack_o = stray_q;
    end

endmodule
